// File: rtl/mux_2x1_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_2x1_arbiter : round-robin owner arbiter driving a 2x1 mux bank select |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_2x1_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       select_o,
  output logic       busy_o
);

  localparam int CW = $clog2(HOLD_MAX) + 1;
  localparam logic [CW-1:0] HCNT_TOP = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          select_q, select_d;

  logic owner;
  logic req_own;
  logic req_oth;
  logic release_now;

  assign owner       = (state_q == GRANT1);
  assign req_own     = req_i[owner];
  assign req_oth     = req_i[~owner];
  // Budget only bites while the other side is actually waiting.
  assign release_now = ~req_own | last_i | (req_oth & (hcnt_q == HCNT_TOP));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      hcnt_q   <= '0;
      select_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hcnt_q   <= hcnt_d;
      select_q <= select_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    select_d = select_q;

    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        case (req_i)
          2'b01:   state_d = GRANT0;
          2'b10:   state_d = GRANT1;
          2'b11:   state_d = ptr_q ? GRANT1 : GRANT0;
          default: state_d = IDLE;
        endcase
      end
      GRANT0, GRANT1: begin
        if (release_now) begin
          ptr_d  = ~owner;
          hcnt_d = '0;
          if (req_oth) begin
            state_d = owner ? GRANT0 : GRANT1;
          end else begin
            state_d = IDLE;
          end
        end else if (hcnt_q != HCNT_TOP) begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase

    // Select follows the new owner; it is left alone in IDLE so the bank
    // keeps steering the last owner's data.
    if (state_d == GRANT0) begin
      select_d = 1'b0;
    end else if (state_d == GRANT1) begin
      select_d = 1'b1;
    end
  end

  assign gnt_o    = {state_q == GRANT1, state_q == GRANT0};
  assign busy_o   = (state_q != IDLE);
  assign select_o = select_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_2x1_arbiter.sv
`default_nettype none
// Testbench for mux_2x1_arbiter: directed test-plan steps followed by random
// traffic, all checked against a cycle-level ownership model.
module tb_mux_2x1_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk_i;
  logic       rst_ni;
  logic [1:0] req_i;
  logic       last_i;
  logic [1:0] gnt_o;
  logic       select_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  // Model: who owns the datapath (-1 = nobody), cycles owned so far,
  // tie-break favourite and the last owner seen by the mux.
  int   m_own;
  int   m_cnt;
  int   m_ptr;
  logic m_sel;

  mux_2x1_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .last_i  (last_i),
    .gnt_o   (gnt_o),
    .select_o(select_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_own = -1;
    m_cnt = 0;
    m_ptr = 0;
    m_sel = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic l);
    int o;
    bit mine, theirs;
    if (m_own < 0) begin
      if (r == 2'b01)      m_own = 0;
      else if (r == 2'b10) m_own = 1;
      else if (r == 2'b11) m_own = m_ptr;
      m_cnt = 0;
      if (m_own >= 0) m_sel = (m_own == 1);
    end else begin
      o      = 1 - m_own;
      mine   = r[m_own];
      theirs = r[o];
      if (!mine || l || (theirs && m_cnt >= HOLD_MAX - 1)) begin
        m_ptr = o;
        m_cnt = 0;
        if (theirs) begin
          m_own = o;
          m_sel = (o == 1);
        end else begin
          m_own = -1;
        end
      end else if (m_cnt < HOLD_MAX - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [1:0] exp_gnt;
    exp_gnt = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    checks++;
    assert (gnt_o === exp_gnt) else begin
      errors++;
      $error("FAIL %s gnt observed=%b expected=%b", tag, gnt_o, exp_gnt);
    end
    checks++;
    assert (select_o === m_sel) else begin
      errors++;
      $error("FAIL %s select observed=%b expected=%b", tag, select_o, m_sel);
    end
    checks++;
    assert (busy_o === (m_own >= 0)) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy_o, (m_own >= 0));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk_i);
    model_step(req_i, last_i);
    #1;
    check(tag);
  endtask

  // Reset pulsed between edges; outputs must clear without a clock edge.
  task automatic pulse_reset();
    #3 rst_ni = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    #2 rst_ni = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_tie;
    rst_ni = 1'b0;
    req_i  = 2'b00;
    last_i = 1'b0;
    model_reset();
    #1;
    check("reset");
    #12 rst_ni = 1'b1;

    // Single requester, then release to IDLE.
    req_i = 2'b01;
    for (int i = 0; i < 10; i++) tick("single");
    req_i = 2'b00;
    tick("single_drop");

    // Reset mid-grant of requester 1, then tie rotation from ptr=0.
    req_i = 2'b10;
    tick("grant1");
    tick("grant1");
    pulse_reset();
    req_i = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick("tie");
      exp_tie = ((i / HOLD_MAX) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      assert (gnt_o === exp_tie) else begin
        errors++;
        $error("FAIL tie_seq[%0d] observed=%b expected=%b", i, gnt_o, exp_tie);
      end
    end

    // last_i handover after two owner cycles.
    req_i = 2'b00;
    tick("idle");
    req_i = 2'b01;
    tick("own0");
    req_i = 2'b11;
    tick("own0_c2");
    last_i = 1'b1;
    tick("last_handover");
    last_i = 1'b0;
    for (int i = 0; i < 5; i++) tick("after_last");

    // Late contender against a saturated owner.
    req_i = 2'b00;
    tick("idle");
    req_i = 2'b10;
    for (int i = 0; i < 6; i++) tick("late_own1");
    req_i = 2'b11;
    tick("late_contender");
    checks++;
    assert (gnt_o === 2'b01) else begin
      errors++;
      $error("FAIL late_contender observed=%b expected=%b", gnt_o, 2'b01);
    end

    // Simultaneous release: owner gone, last beat and budget all at once.
    req_i = 2'b00;
    tick("idle");
    req_i = 2'b01;
    for (int i = 0; i < 5; i++) tick("sim_own0");
    req_i  = 2'b10;
    last_i = 1'b1;
    tick("sim_release");
    last_i = 1'b0;
    tick("sim_own1");
    req_i = 2'b00;
    tick("sim_idle");
    req_i = 2'b11;
    tick("sim_tie");
    checks++;
    assert (gnt_o === 2'b01) else begin
      errors++;
      $error("FAIL sim_tie observed=%b expected=%b", gnt_o, 2'b01);
    end

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 63) == 0) pulse_reset();
      req_i  = 2'($urandom_range(0, 3));
      last_i = ($urandom_range(0, 7) == 0);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
